eviction_write_queue: RTL

- Multi-entry successor to the single-line eviction write buffer; sits between the cache (or L2) eviction path and physical memory.
- Accepts dirty lines on eviction and retires them to pmem one at a time, in FIFO order.
- Forwards buffered data to reads whose address matches an entry.
- Defers new writebacks while a pmem read is pending, so misses are served first.

---
 rtl/eviction_write_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/eviction_write_queue.sv
// Multi-entry eviction write queue: buffers dirty lines, retires them to pmem in FIFO order
// and forwards buffered data to matching reads. Define EWB_COALESCE_EN to merge same-address pushes.
module eviction_write_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_valid,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [LINE_W-1:0]      wr_data,
   output logic                   wr_ready,
   input  logic                   rd_req,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic                   rd_hit,
   output logic [LINE_W-1:0]      rd_data,
   output logic                   mem_write,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [LINE_W-1:0]      mem_wdata,
   input  logic                   mem_resp,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, WRITING} state_t;

   state_t            r_state;
   logic              r_mem_write;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [DEPTH-1:0]  r_valid;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [LINE_W-1:0] r_data [DEPTH];

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_alloc;
   logic              w_pop;
   logic [PTR_W-1:0]  w_wr_idx;
`ifdef EWB_COALESCE_EN
   logic              w_coal_hit;
   logic [PTR_W-1:0]  w_coal_idx;
`endif

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = (r_state == WRITING) && mem_resp;

   // Walk entries oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx     = '0;
      rd_hit  = 1'b0;
      rd_data = '0;
`ifdef EWB_COALESCE_EN
      w_coal_hit = 1'b0;
      w_coal_idx = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = r_head + PTR_W'(k);
         if (r_valid[idx] && (r_addr[idx] == rd_addr)) begin
            rd_hit  = 1'b1;
            rd_data = r_data[idx];
         end
`ifdef EWB_COALESCE_EN
         if (r_valid[idx] && (r_addr[idx] == wr_addr) && !((k == 0) && (r_state == WRITING))) begin
            w_coal_hit = 1'b1;
            w_coal_idx = idx;
         end
`endif
      end
   end

`ifdef EWB_COALESCE_EN
   assign wr_ready = !w_full || w_coal_hit;
   assign w_push   = wr_valid && wr_ready;
   assign w_alloc  = w_push && !w_coal_hit;
   assign w_wr_idx = w_coal_hit ? w_coal_idx : r_tail;
`else
   assign wr_ready = !w_full;
   assign w_push   = wr_valid && wr_ready;
   assign w_alloc  = w_push;
   assign w_wr_idx = r_tail;
`endif

   // Control state: pointers, valid bits, occupancy and the writeback FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_mem_write <= 1'b0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_valid     <= '0;
      end else begin
         if (w_alloc) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         case ({w_alloc, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         case (r_state)
            IDLE: begin
               if (!w_empty && !rd_req) begin
                  r_state     <= WRITING;
                  r_mem_write <= 1'b1;
               end
            end
            WRITING: begin
               if (mem_resp) begin
                  r_state     <= IDLE;
                  r_mem_write <= 1'b0;
               end
            end
         endcase
      end
   end

   // Line storage carries no reset; validity lives in r_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[w_wr_idx] <= wr_addr;
         r_data[w_wr_idx] <= wr_data;
      end
   end

   assign mem_write = r_mem_write;
   assign mem_addr  = r_addr[r_head];
   assign mem_wdata = r_data[r_head];
   assign count     = r_count;
   assign empty     = w_empty;

endmodule
